// File: rtl/i2c.sv
// i2c: single-master I2C controller.
// One bus transaction per startTxRx pulse: START, address + R/W, lenMsg data bytes, STOP.
// The bit timer runs in quarter periods of Q = BIT_CLKS/4 clocks.
// Each bit is q0-q1 with SCL low and q2-q3 with SCL high.
// SDA changes at the start of q0. Slave SDA is sampled on the last clock of q2.
//
// Ports
//   clock, reset              system clock, async active-low reset
//   addr, lenMsg, rdWr        command, latched when startTxRx is taken in IDLE
//   startTxRx                 one-cycle start pulse
//   inData/inValid/inReady    write byte stream (consumed in WR_LOAD)
//   outData/outValid/outReady read byte stream (presented in RD_WAIT)
//   sda, scl                  open-drain bus pads
//   i2c_sda_oe                1 = master drives SDA
//   i2c_scl_oe                1 = SCL released, 0 = SCL pulled low
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | bus released, waiting for startTxRx
// S_START    | SDA 1 -> 0 with SCL high, then SCL low
// S_ADDR     | shifting out {addr, rdWr}
// S_ADDR_ACK | SDA released, sample slave ACK for the address
// S_WR_LOAD  | SCL held low, waiting for a write byte
// S_WR_DATA  | shifting out a write byte
// S_WR_ACK   | SDA released, sample slave ACK for the write byte
// S_RD_DATA  | SDA released, shifting in a read byte
// S_RD_WAIT  | SCL held low, read byte offered on outData
// S_RD_ACK   | master ACK (more bytes follow) or NACK (last byte)
// S_STOP     | SDA 0 -> 1 with SCL high, then SDA released
module i2c #(
   parameter int BIT_CLKS = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] addr,
   input  logic [7:0] lenMsg,
   input  logic       rdWr,
   input  logic       startTxRx,
   input  logic [7:0] inData,
   input  logic       inValid,
   output logic       inReady,
   output logic [7:0] outData,
   output logic       outValid,
   input  logic       outReady,
   inout  wire        sda,
   inout  wire        scl,
   output logic       i2c_sda_oe,
   output logic       i2c_scl_oe
);

   localparam int Q  = BIT_CLKS / 4;
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_LOAD, S_WR_DATA,
      S_WR_ACK, S_RD_DATA, S_RD_WAIT, S_RD_ACK, S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    phase_q, phase_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    byte_q, byte_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          rd_wr_q, rd_wr_d;
   logic          ack_q, ack_d;

   logic sda_bit, sda_in, scl_in;
   logic run, stall, sample, bit_end;

   assign sda     = i2c_sda_oe ? sda_bit : 1'bz;
   assign scl     = i2c_scl_oe ? 1'bz : 1'b0;
   assign sda_in  = sda;
   assign scl_in  = scl;
   assign outData = out_data_q;

   always_comb begin
      state_d    = state_q;
      qcnt_d     = qcnt_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      byte_d     = byte_q;
      shift_d    = shift_q;
      out_data_d = out_data_q;
      rd_wr_d    = rd_wr_q;
      ack_d      = ack_q;
      i2c_sda_oe = 1'b0;
      i2c_scl_oe = 1'b1;
      sda_bit    = 1'b1;
      inReady    = 1'b0;
      outValid   = 1'b0;
      run        = 1'b0;

      case (state_q)
         S_START: begin
            run        = 1'b1;
            i2c_sda_oe = 1'b1;
            sda_bit    = (phase_q == 2'd0);
            i2c_scl_oe = ~phase_q[1];
         end
         S_ADDR, S_WR_DATA: begin
            run        = 1'b1;
            i2c_sda_oe = 1'b1;
            sda_bit    = shift_q[7];
            i2c_scl_oe = phase_q[1];
         end
         S_ADDR_ACK, S_WR_ACK, S_RD_DATA: begin
            run        = 1'b1;
            i2c_scl_oe = phase_q[1];
         end
         S_RD_ACK: begin
            run        = 1'b1;
            i2c_sda_oe = 1'b1;
            sda_bit    = (byte_q == 8'd1);
            i2c_scl_oe = phase_q[1];
         end
         S_WR_LOAD: begin
            i2c_scl_oe = 1'b0;
            inReady    = 1'b1;
         end
         S_RD_WAIT: begin
            i2c_scl_oe = 1'b0;
            outValid   = 1'b1;
         end
         S_STOP: begin
            run        = 1'b1;
            i2c_sda_oe = (phase_q != 2'd3);
            sda_bit    = (phase_q == 2'd2);
            i2c_scl_oe = (phase_q != 2'd0);
         end
         default: ;
      endcase

      // A released SCL still read low means a slave is stretching the clock.
      stall   = i2c_scl_oe && !scl_in;
      sample  = run && !stall && (qcnt_q == '0) && (phase_q == 2'd2);
      bit_end = run && !stall && (qcnt_q == '0) && (phase_q == 2'd3);

      if (!run) begin
         qcnt_d  = Q_LAST;
         phase_d = 2'd0;
      end else if (!stall) begin
         if (qcnt_q == '0) begin
            qcnt_d  = Q_LAST;
            phase_d = phase_q + 2'd1;
         end else begin
            qcnt_d = qcnt_q - 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (startTxRx) begin
               shift_d = {addr, rdWr};
               rd_wr_d = rdWr;
               byte_d  = lenMsg;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_d   = 3'd0;
               state_d = S_ADDR;
            end
         end
         S_ADDR, S_WR_DATA: begin
            if (bit_end) begin
               shift_d = {shift_q[6:0], 1'b0};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7)
                  state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
            end
         end
         S_ADDR_ACK: begin
            if (sample) ack_d = sda_in;
            if (bit_end) begin
               bit_d = 3'd0;
               if (ack_q || byte_q == 8'd0) state_d = S_STOP;
               else if (rd_wr_q)            state_d = S_RD_DATA;
               else                         state_d = S_WR_LOAD;
            end
         end
         S_WR_LOAD: begin
            if (inValid) begin
               shift_d = inData;
               bit_d   = 3'd0;
               state_d = S_WR_DATA;
            end
         end
         S_WR_ACK: begin
            if (sample) ack_d = sda_in;
            if (bit_end) begin
               if (ack_q) begin
                  state_d = S_STOP;
               end else begin
                  byte_d  = byte_q - 8'd1;
                  state_d = (byte_q == 8'd1) ? S_STOP : S_WR_LOAD;
               end
            end
         end
         S_RD_DATA: begin
            if (sample) shift_d = {shift_q[6:0], sda_in};
            if (bit_end) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  out_data_d = shift_q;
                  state_d    = S_RD_WAIT;
               end
            end
         end
         S_RD_WAIT: begin
            if (outReady) state_d = S_RD_ACK;
         end
         S_RD_ACK: begin
            if (bit_end) begin
               bit_d   = 3'd0;
               byte_d  = byte_q - 8'd1;
               state_d = (byte_q == 8'd1) ? S_STOP : S_RD_DATA;
            end
         end
         S_STOP: begin
            if (bit_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         qcnt_q     <= Q_LAST;
         phase_q    <= 2'd0;
         bit_q      <= 3'd0;
         byte_q     <= 8'd0;
         shift_q    <= 8'd0;
         out_data_q <= 8'd0;
         rd_wr_q    <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         qcnt_q     <= qcnt_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         shift_q    <= shift_d;
         out_data_q <= out_data_d;
         rd_wr_q    <= rd_wr_d;
         ack_q      <= ack_d;
      end
   end

endmodule

// File: tb/tb_i2c.sv
// tb_i2c: scoreboard bench for the i2c master, with a bus-level slave model.
// Expected bus/stream events are queued when a command is issued. The monitor
// pops and compares them as it observes addresses, write bytes, read bytes,
// master ACK bits and STOP.
module tb_i2c;
   localparam int BIT = 16;

   localparam logic [3:0] K_ADDR = 4'd1, K_WB = 4'd2, K_RD = 4'd3, K_MACK = 4'd4, K_STOP = 4'd5;

   typedef struct packed {
      logic [3:0] kind;
      logic [7:0] val;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] addr = '0;
   logic [7:0] lenMsg = '0;
   logic       rdWr = 1'b0;
   logic       startTxRx = 1'b0;
   logic [7:0] inData = '0;
   logic       inValid = 1'b0;
   logic       inReady;
   logic [7:0] outData;
   logic       outValid;
   logic       outReady = 1'b1;
   logic       i2c_sda_oe, i2c_scl_oe;
   wire        sda, scl;

   logic       slave_bit = 1'b1;
   logic       ack_val = 1'b0;
   logic [7:0] rd_list [4];

   assign sda = i2c_sda_oe ? 1'bz : slave_bit;
   assign scl = i2c_scl_oe ? 1'b1 : 1'bz;

   i2c #(.BIT_CLKS(BIT)) dut (
      .clock(clock), .reset(reset), .addr(addr), .lenMsg(lenMsg), .rdWr(rdWr),
      .startTxRx(startTxRx), .inData(inData), .inValid(inValid), .inReady(inReady),
      .outData(outData), .outValid(outValid), .outReady(outReady),
      .sda(sda), .scl(scl), .i2c_sda_oe(i2c_sda_oe), .i2c_scl_oe(i2c_scl_oe)
   );

   always #5 clock = ~clock;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, start_cyc = 0, stop_cyc = 0, stop_cnt = 0;
   int wr_hs = 0, inrdy_cyc = 0;
   ev_t exp_q[$];

   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] k, input logic [7:0] v);
      exp_q.push_back('{kind: k, val: v});
   endtask

   task automatic got(input logic [3:0] k, input logic [7:0] v);
      ev_t e;
      if (exp_q.size() == 0) begin
         chk("sb_extra", {20'h0, k, v}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         chk("sb_event", {20'h0, k, v}, {20'h0, e.kind, e.val});
      end
   endtask

   // Bus monitor and slave model. pos is the bit slot within a 9-bit frame;
   // frame 0 carries the address, later frames carry data.
   logic       scl_p = 1'b1, sda_p = 1'b1, in_txn = 1'b0, rw = 1'b0;
   logic [7:0] sh = '0;
   int         pos = 0, frame = 0;

   always @(negedge clock) begin
      if (!reset) begin
         in_txn    = 1'b0;
         slave_bit = 1'b1;
         scl_p     = 1'b1;
         sda_p     = 1'b1;
      end else begin
         if (outValid && outReady) got(K_RD, outData);
         if (inValid && inReady) wr_hs++;
         if (inReady) inrdy_cyc++;

         if (scl && scl_p && sda_p && !sda) begin
            in_txn = 1'b1;
            pos    = -1;
            frame  = 0;
         end else if (in_txn && scl && scl_p && !sda_p && sda) begin
            in_txn    = 1'b0;
            slave_bit = 1'b1;
            stop_cnt++;
            stop_cyc  = cyc;
            got(K_STOP, 8'h00);
         end else if (in_txn && scl && !scl_p && pos >= 0) begin
            if (pos < 8) begin
               sh = {sh[6:0], sda};
               if (pos == 7) begin
                  if (frame == 0) begin
                     rw = sda;
                     got(K_ADDR, sh);
                  end else if (!rw) begin
                     got(K_WB, sh);
                  end
               end
            end else if (frame > 0 && rw) begin
               got(K_MACK, {7'h0, sda});
            end
         end else if (in_txn && !scl && scl_p) begin
            pos++;
            if (pos == 9) begin
               pos = 0;
               frame++;
            end
            if (pos == 8 && (frame == 0 || !rw)) slave_bit = ack_val;
            else if (frame > 0 && rw && pos < 8) slave_bit = rd_list[(frame - 1) % 4][7 - pos];
            else slave_bit = 1'b1;
         end
         scl_p = scl;
         sda_p = sda;
      end
   end

   task automatic start_cmd(input logic [6:0] a, input logic [7:0] len, input logic rw_i);
      @(posedge clock); #1;
      addr = a; lenMsg = len; rdWr = rw_i; startTxRx = 1'b1;
      @(posedge clock); #1;
      startTxRx = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_stop(input string tag, input int budget);
      int s0;
      s0 = stop_cnt;
      for (int i = 0; i < budget && stop_cnt == s0; i++) @(posedge clock);
      chk({tag, "_stop_seen"}, stop_cnt - s0, 1);
      repeat (2 * BIT) @(posedge clock);
      #1;
      chk({tag, "_q_drain"}, exp_q.size(), 0);
      chk({tag, "_idle_sda_oe"}, i2c_sda_oe, 1'b0);
      chk({tag, "_idle_scl_oe"}, i2c_scl_oe, 1'b1);
   endtask

   task automatic async_rst(input string tag);
      @(posedge clock); #3;
      reset = 1'b0;
      #1;
      chk({tag, "_sda_oe"}, i2c_sda_oe, 1'b0);
      chk({tag, "_scl_oe"}, i2c_scl_oe, 1'b1);
      chk({tag, "_outValid"}, outValid, 1'b0);
      chk({tag, "_inReady"}, inReady, 1'b0);
      chk({tag, "_q"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int hs0, ir0, bad;
      rd_list[0] = 8'h4B; rd_list[1] = 8'h96; rd_list[2] = 8'h00; rd_list[3] = 8'h00;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_inReady", inReady, 1'b0);
      chk("rst_outValid", outValid, 1'b0);
      chk("rst_outData", outData, 8'h00);
      chk("rst_sda_oe", i2c_sda_oe, 1'b0);
      chk("rst_scl_oe", i2c_scl_oe, 1'b1);
      reset = 1'b1;
      repeat (2) @(posedge clock);

      // Address NACK
      ack_val = 1'b1;
      push(K_ADDR, 8'h20); push(K_STOP, 8'h00);
      ir0 = inrdy_cyc;
      start_cmd(7'h10, 8'd1, 1'b0);
      wait_stop("nack", 4000);
      chk("nack_time", ((stop_cyc - start_cyc) >= 10 * BIT) && ((stop_cyc - start_cyc) <= 11 * BIT), 1'b1);
      chk("nack_inReady", inrdy_cyc - ir0, 0);

      // Single write
      ack_val = 1'b0; inData = 8'h4A; inValid = 1'b1;
      push(K_ADDR, 8'h20); push(K_WB, 8'h4A); push(K_STOP, 8'h00);
      hs0 = wr_hs; ir0 = inrdy_cyc;
      start_cmd(7'h10, 8'd1, 1'b0);
      wait_stop("wr1", 4000);
      chk("wr1_hs", wr_hs - hs0, 1);
      chk("wr1_inReady_cyc", inrdy_cyc - ir0, 1);

      // Two-byte write; a second start and command changes mid-transfer are ignored
      push(K_ADDR, 8'h20); push(K_WB, 8'h4A); push(K_WB, 8'h4A); push(K_STOP, 8'h00);
      hs0 = wr_hs;
      start_cmd(7'h10, 8'd2, 1'b0);
      repeat (40) @(posedge clock);
      #1;
      addr = 7'h55; lenMsg = 8'd9; rdWr = 1'b1; startTxRx = 1'b1;
      @(posedge clock); #1;
      startTxRx = 1'b0;
      wait_stop("wr2", 6000);
      chk("wr2_hs", wr_hs - hs0, 2);
      inValid = 1'b0;

      // Read two bytes
      outReady = 1'b1;
      push(K_ADDR, 8'h21); push(K_RD, 8'h4B); push(K_MACK, 8'h00);
      push(K_RD, 8'h96); push(K_MACK, 8'h01); push(K_STOP, 8'h00);
      start_cmd(7'h10, 8'd2, 1'b1);
      wait_stop("rd2", 6000);

      // Read backpressure
      rd_list[0] = 8'hC5; outReady = 1'b0;
      push(K_ADDR, 8'h75); push(K_RD, 8'hC5); push(K_MACK, 8'h01); push(K_STOP, 8'h00);
      start_cmd(7'h3A, 8'd1, 1'b1);
      for (int i = 0; i < 3000 && !outValid; i++) @(negedge clock);
      chk("rdbp_valid", outValid, 1'b1);
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clock);
         if (i2c_scl_oe !== 1'b0 || outValid !== 1'b1 || outData !== 8'hC5) bad++;
      end
      chk("rdbp_hold", bad, 0);
      @(posedge clock); #1;
      outReady = 1'b1;
      wait_stop("rdbp", 4000);

      // Write backpressure
      inData = 8'hE7; inValid = 1'b0;
      push(K_ADDR, 8'h74); push(K_WB, 8'hE7); push(K_STOP, 8'h00);
      start_cmd(7'h3A, 8'd1, 1'b0);
      for (int i = 0; i < 3000 && !inReady; i++) @(negedge clock);
      chk("wrbp_ready", inReady, 1'b1);
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clock);
         if (i2c_scl_oe !== 1'b0 || inReady !== 1'b1) bad++;
      end
      chk("wrbp_hold", bad, 0);
      @(posedge clock); #1;
      inValid = 1'b1;
      wait_stop("wrbp", 4000);
      inValid = 1'b0;

      // Async reset in the middle of a write data byte
      inData = 8'h4A; inValid = 1'b1;
      push(K_ADDR, 8'h20);
      start_cmd(7'h10, 8'd1, 1'b0);
      repeat (12 * BIT + 5) @(posedge clock);
      #1;
      chk("wrrst_pre_sda_oe", i2c_sda_oe, 1'b1);
      async_rst("wrrst");
      inValid = 1'b0;

      // Async reset while a read byte is waiting
      rd_list[0] = 8'h5A; outReady = 1'b0;
      push(K_ADDR, 8'h21);
      start_cmd(7'h10, 8'd2, 1'b1);
      for (int i = 0; i < 3000 && !outValid; i++) @(negedge clock);
      chk("rdrst_pre_valid", outValid, 1'b1);
      async_rst("rdrst");
      outReady = 1'b1;
      repeat (4) @(posedge clock);

      // Normal write after reset
      inData = 8'h4A; inValid = 1'b1;
      push(K_ADDR, 8'h20); push(K_WB, 8'h4A); push(K_STOP, 8'h00);
      hs0 = wr_hs;
      start_cmd(7'h10, 8'd1, 1'b0);
      wait_stop("post", 4000);
      chk("post_hs", wr_hs - hs0, 1);
      inValid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/i2c.md
Name: i2c

Overview:
- Single-master I2C controller. Executes one bus transaction per `startTxRx` pulse: START, 7-bit address plus R/W bit, then `lenMsg` data bytes, then STOP.
- Write bytes come in on a valid/ready stream; read bytes go out on a valid/ready stream.
- Sits between a system-side command/stream interface and open-drain SDA/SCL pads.

Parameters:
- BIT_CLKS, 1024, system clocks per SCL bit period. Must be a multiple of 4; quarter period Q = BIT_CLKS/4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  7  slave address, latched on start.
- lenMsg  in  8  number of data bytes, latched on start.
- rdWr  in  1  0 = write, 1 = read, latched on start.
- startTxRx  in  1  one-cycle start pulse; honoured only in IDLE.
- inData  in  8  write byte.
- inValid  in  1  inData valid.
- inReady  out  1  core accepts inData this cycle.
- outData  out  8  received byte.
- outValid  out  1  outData valid.
- outReady  in  1  consumer accepts outData.
- sda  inout  1  I2C data. Driven with the internal SDA bit when i2c_sda_oe=1, else high-Z.
- scl  inout  1  I2C clock. Driven 0 when i2c_scl_oe=0, high-Z when i2c_scl_oe=1 (external pull-up gives 1).
- i2c_sda_oe  out  1  1 = master drives SDA.
- i2c_scl_oe  out  1  1 = SCL released (high), 0 = SCL pulled low.

Behaviour:
- Reset (async, reset=0) forces:
  - state IDLE; inReady=0, outValid=0, outData=0.
  - i2c_sda_oe=0, i2c_scl_oe=1, all counters cleared.
- IDLE: SDA released, SCL released. On startTxRx=1, latch addr/lenMsg/rdWr, shift register = {addr, rdWr}, go to START.
- Bus timing:
  - Each bit is 4 quarters of Q clocks: q0-q1 SCL low, q2-q3 SCL high.
  - Master changes SDA at the start of q0.
  - Slave SDA is sampled once, on the last clock of q2.
- START (4Q): drive SDA=1 for Q with SCL high, drive SDA=0 for Q with SCL high, then pull SCL low for 2Q. Go to ADDR.
- ADDR: shift 8 bits MSB first with SDA driven, then ADDR_ACK.
- ADDR_ACK: release SDA for one bit and sample it.
  - SDA=1 (NACK): go to STOP.
  - SDA=0 with lenMsg=0: go to STOP.
  - SDA=0, rdWr=0: go to WR_LOAD.
  - SDA=0, rdWr=1: go to RD_DATA.
- WR_LOAD (SCL held low, master stretch):
  - inReady=1 until inValid=1; the byte transfers on the cycle inValid&inReady.
  - Load the shift register, deassert inReady the next cycle, go to WR_DATA.
  - The bus waits indefinitely for inValid.
- WR_DATA: 8 bits MSB first, then WR_ACK (release SDA, sample).
  - NACK: go to STOP.
  - ACK: decrement the remaining-byte count; go to STOP if zero, else WR_LOAD.
- RD_DATA: SDA released; 8 bits sampled MSB first into the shift register, then RD_WAIT.
- RD_WAIT (SCL low):
  - outData = byte, outValid=1 until outReady=1.
  - Handshake cycle clears outValid and goes to RD_ACK.
- RD_ACK: drive SDA=0 (ACK) if bytes remain after this one, SDA=1 (NACK) for the last byte.
  - Then go to RD_DATA, or to STOP after the last byte.
- STOP (4Q): drive SDA=0 with SCL low for Q, release SCL for Q, drive SDA=1 for Q, then release SDA for Q. Return to IDLE.
- Busy handling:
  - startTxRx while not IDLE is ignored.
  - inValid outside WR_LOAD is ignored (inReady=0).
  - Input changes to addr/lenMsg/rdWr after the start pulse have no effect.
- Counters: bit counter 0..7; byte counter 8-bit, loaded with lenMsg.
- Reset mid-transaction: bus released immediately (SDA high-Z, SCL high), no STOP generated.

Test Plan:
- Address NACK:
  - Stimulus: addr=0x10, rdWr=0, lenMsg=1, pulse start, slave SDA=1.
  - Expect: START, bits 0x20 on SDA, NACK sampled, STOP, back to IDLE after ~10×BIT_CLKS.
  - Expect: inReady never asserted.
- Single write:
  - Stimulus: same command, slave holds SDA=0, inData=0x4A, inValid=1.
  - Expect: inReady pulses once.
  - Expect: SDA carries 0x20 then 0x4A at SCL rising edges, each followed by a released ACK bit, then STOP.
- Two-byte write:
  - Stimulus: lenMsg=2, inValid held with 0x4A.
  - Expect: two inReady handshakes, 0x4A sent twice, STOP after the second ACK.
- Read two bytes:
  - Stimulus: rdWr=1, lenMsg=2, outReady=1, slave ACKs address and drives 0x4B.
  - Expect: first byte 0x21; outValid pulses with outData=0x4B.
  - Expect: master ACK (SDA=0) after byte 1 and NACK (SDA=1) after byte 2, then STOP.
- Backpressure:
  - Stimulus: read with outReady=0 for 5000 clocks.
  - Expect: SCL held low (i2c_scl_oe=0) and outValid=1 stable until outReady rises.
  - Same check on the write side with inValid=0: SCL held low until inValid rises.
- Async reset:
  - Stimulus: reset=0 mid-byte.
  - Expect: within the same cycle i2c_sda_oe=0, i2c_scl_oe=1, outValid=0, inReady=0.
  - Expect: a new start after release works normally.
